// File: rtl/and4_bist_pkg.sv
// Shared types and constants for the AND4 built-in self-test sequencer.
package and4_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [3:0] VEC_LAST = 4'hF;
  localparam int ERR_W = 5;
  localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;

  // Saturating increment for the mismatch counter.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/and4_bist_vecgen.sv
// Vector, sweep and settle counters for the AND4 BIST; vec doubles as the
// registered cell-input drive and is zero whenever the sequencer is not running.
module and4_bist_vecgen
  import and4_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int REPEAT     = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       drive_i,
  input  logic       sample_i,
  output logic [3:0] vec_o,
  output logic       sample_now_o,
  output logic       last_vec_o
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] SWEEP_LAST  = 4'(REPEAT - 1);

  logic [7:0] settle_q;
  logic [3:0] vec_q;
  logic [3:0] sweep_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      settle_q <= '0;
      vec_q    <= '0;
      sweep_q  <= '0;
    end else if (drive_i) begin
      settle_q <= sample_now_o ? 8'd0 : settle_q + 8'd1;
    end else if (sample_i) begin
      // vec wraps 15 -> 0 naturally, leaving DUT_I at 0 after the final sample
      vec_q <= vec_q + 4'd1;
      if (vec_q == VEC_LAST) sweep_q <= sweep_q + 4'd1;
    end
  end

  assign sample_now_o = drive_i && (settle_q == SETTLE_LAST);
  assign last_vec_o   = (vec_q == VEC_LAST) && (sweep_q == SWEEP_LAST);
  assign vec_o        = vec_q;

endmodule

// File: rtl/and4_bist_ctrl.sv
// AND4 BIST sequencer top: run FSM, error counting and pass/done flags.
// Optional first-failure capture is enabled with AND4_BIST_FAIL_CAPTURE_EN.
module and4_bist_ctrl
  import and4_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int REPEAT     = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [3:0]       dut_i_o,
  input  logic             dut_o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o
`ifdef AND4_BIST_FAIL_CAPTURE_EN
  ,
  output logic [3:0]       fail_vec_o,
  output logic             fail_valid_o
`endif
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       vec;
  logic             sample_now;
  logic             last_vec;
  logic             accept;
  logic             kill;
  logic             mismatch;

  assign accept   = (state_q == ST_IDLE) && start_i && !abort_i;
  assign kill     = (state_q != ST_IDLE) && abort_i;
  assign mismatch = dut_o_i != (vec == VEC_LAST);

  always_comb begin
    err_d = err_q;
    if (mismatch) err_d = err_inc(err_q);
  end

  and4_bist_vecgen #(
    .SETTLE_CYC(SETTLE_CYC),
    .REPEAT    (REPEAT)
  ) u_vecgen (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (accept || kill),
    .drive_i     (state_q == ST_DRIVE),
    .sample_i    (state_q == ST_SAMPLE),
    .vec_o       (vec),
    .sample_now_o(sample_now),
    .last_vec_o  (last_vec)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else if (kill) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= ST_DRIVE;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
          end
        end
        ST_DRIVE: begin
          if (sample_now) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          if (last_vec) begin
            // pass reflects the count including this final sample
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ST_DRIVE;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef AND4_BIST_FAIL_CAPTURE_EN
  logic [3:0] fail_vec_q;
  logic       fail_valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || accept) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (!kill && (state_q == ST_SAMPLE) && mismatch && !fail_valid_q) begin
      fail_vec_q   <= vec;
      fail_valid_q <= 1'b1;
    end
  end

  assign fail_vec_o   = fail_vec_q;
  assign fail_valid_o = fail_valid_q;
`endif

  assign dut_i_o   = vec;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

endmodule
